// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide/accumulate unit.
// EX decodes aluop into op_i with these constants.
package muldiv_iter_pkg;

    localparam int         MD_SIGNED = 0;
    localparam logic [1:0] MD_MULT   = 2'b00;
    localparam logic [1:0] MD_DIV    = 2'b01;
    localparam logic [1:0] MD_MADD   = 2'b10;
    localparam logic [1:0] MD_MSUB   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } mdState_t;

endpackage

// File: rtl/muldiv_iter_md_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring trial-subtract for divide, on unsigned magnitudes.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_addSum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // Multiply: lo holds the remaining multiplier bits, hi the running partial sum.
    assign w_addSum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);

    // Divide: a successful subtract always leaves a value below the divisor, so WIDTH bits suffice.
    assign w_shifted = {i_hi, i_lo[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, i_operand});
    assign w_diff    = w_shifted[WIDTH-1:0] - i_operand;

    always_comb begin
        if (i_isDiv) begin
            o_hi = w_fits ? w_diff : w_shifted[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_fits};
        end else begin
            o_hi = w_addSum[WIDTH:1];
            o_lo = {w_addSum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/DIV/MADD/MSUB engine for EX: WIDTH magnitude steps, one sign/accumulate
// fixup cycle, then a held {hi,lo} result until EX drops start_i.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);
    import muldiv_iter_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdState_t             r_state;
    logic [CNT_W-1:0]     r_count;
    logic [1:0]           r_kind;
    logic                 r_neg1;
    logic                 r_neg2;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_operand;
    logic [2*WIDTH-1:0]   r_hilo;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;
    logic                 r_busy;

    logic                 w_launchDiv;
    logic                 w_divByZero;
    logic                 w_sign1;
    logic                 w_sign2;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH-1:0]     w_stepHi;
    logic [WIDTH-1:0]     w_stepLo;
    logic [2*WIDTH-1:0]   w_prodMag;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_fixed;

    assign w_launchDiv = (op_i[2:1] == MD_DIV);
    assign w_divByZero = w_launchDiv && (opdata2_i == '0);
    assign w_sign1     = op_i[MD_SIGNED] & opdata1_i[WIDTH-1];
    assign w_sign2     = op_i[MD_SIGNED] & opdata2_i[WIDTH-1];
    assign w_abs1      = w_sign1 ? -opdata1_i : opdata1_i;
    assign w_abs2      = w_sign2 ? -opdata2_i : opdata2_i;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_isDiv   (r_kind == MD_DIV),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_operand (r_operand),
        .o_hi      (w_stepHi),
        .o_lo      (w_stepLo)
    );

    // Most-negative / -1 lands on magnitude 2^(WIDTH-1), which negates back to itself.
    assign w_prodMag = {r_hi, r_lo};
    assign w_prod    = (r_neg1 ^ r_neg2) ? -w_prodMag : w_prodMag;
    assign w_quot    = (r_neg1 ^ r_neg2) ? -r_lo : r_lo;
    assign w_rem     = r_neg1 ? -r_hi : r_hi;

    always_comb begin
        w_fixed = w_prod;
        case (r_kind)
            MD_DIV:  w_fixed = {w_rem, w_quot};
            MD_MADD: w_fixed = r_hilo + w_prod;
            MD_MSUB: w_fixed = r_hilo - w_prod;
            default: w_fixed = w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_kind    <= MD_MULT;
            r_neg1    <= 1'b0;
            r_neg2    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
            r_hilo    <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (start_i && !annul_i) begin
                        r_kind <= op_i[2:1];
                        r_neg1 <= w_sign1;
                        r_neg2 <= w_sign2;
                        r_hilo <= hilo_i;
                        if (w_divByZero) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_CALC;
                            r_busy    <= 1'b1;
                            r_count   <= '0;
                            r_hi      <= '0;
                            r_lo      <= w_launchDiv ? w_abs1 : w_abs2;
                            r_operand <= w_launchDiv ? w_abs2 : w_abs1;
                        end
                    end
                end
                ST_CALC: begin
                    if (annul_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hi    <= w_stepHi;
                        r_lo    <= w_stepLo;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(WIDTH - 1)) begin
                            r_state <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    r_busy <= 1'b0;
                    if (annul_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state  <= ST_DONE;
                        r_result <= w_fixed;
                        r_ready  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!start_i || annul_i) begin
                        r_state  <= ST_IDLE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: vector table through a result scoreboard,
// plus hand-driven annul, reset and DONE-hold sequences.
module tb_muldiv_iter;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MADDU = 3'b100;
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MSUBU = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] expResult;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        annul;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] hilo;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [63:0] scoreboard[$];
    vec_t        vecs[$];

    muldiv_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .annul_i   (annul),
        .op_i      (op),
        .opdata1_i (opA),
        .opdata2_i (opB),
        .hilo_i    (hilo),
        .result_o  (result),
        .ready_o   (ready),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] refModel(input logic [2:0] mOp, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint sa;
        longint sb;
        longint prod;
        longint q;
        longint r;
        sa = mOp[0] ? longint'($signed(a)) : longint'({32'h0, a});
        sb = mOp[0] ? longint'($signed(b)) : longint'({32'h0, b});
        prod = sa * sb;
        case (mOp[2:1])
            2'b00: return prod;
            2'b01: begin
                if (b == 32'h0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            2'b10: return acc + prod;
            default: return acc - prod;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, wait for ready within a bound, then check latency, busy and result.
    task automatic applyStimulus(input vec_t v, input int holdCycles);
        int          cycles;
        int          expLat;
        logic        sawBusy;
        logic        isDivZero;
        logic [63:0] expected;
        isDivZero = (v.op[2:1] == 2'b01) && (v.b == 32'h0);
        expLat    = isDivZero ? 1 : 34;
        scoreboard.push_back(v.expResult);
        op = v.op; opA = v.a; opB = v.b; hilo = v.hilo;
        start = 1'b1;
        cycles = 0;
        sawBusy = 1'b0;
        while (cycles < 100) begin
            tick();
            cycles++;
            if (busy) sawBusy = 1'b1;
            if (ready) break;
        end
        // Later operand changes must not disturb the latched copies.
        opA = ~v.a; opB = v.b + 32'd3; hilo = ~v.hilo; op = ~v.op;
        checkOutput({v.name, " latency"}, 64'(cycles), 64'(expLat));
        checkOutput({v.name, " busy seen"}, 64'(sawBusy), 64'(!isDivZero));
        expected = scoreboard.pop_front();
        checkOutput({v.name, " result"}, result, expected);
        for (int h = 0; h < holdCycles; h++) begin
            tick();
            checkOutput({v.name, " hold ready"}, 64'(ready), 64'd1);
            checkOutput({v.name, " hold result"}, result, expected);
        end
        start = 1'b0;
        tick();
        checkOutput({v.name, " release ready"}, 64'(ready), 64'd0);
        checkOutput({v.name, " release result"}, result, 64'h0);
    endtask

    function automatic vec_t mkVec(input string name, input logic [2:0] vOp, input logic [31:0] a,
                                   input logic [31:0] b, input logic [63:0] acc, input logic [63:0] exp);
        vec_t v;
        v.name = name; v.op = vOp; v.a = a; v.b = b; v.hilo = acc; v.expResult = exp;
        return v;
    endfunction

    initial begin
        vec_t rv;
        int   cycles;
        logic sawReady;

        vecs.push_back(mkVec("div neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 64'h0, 64'hFFFFFFFF_FFFFFFFD));
        vecs.push_back(mkVec("mult", OP_MULT, 32'hFFFFFFFF, 32'h2, 64'h0, 64'hFFFFFFFF_FFFFFFFE));
        vecs.push_back(mkVec("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 64'h0, 64'h00000001_FFFFFFFE));
        vecs.push_back(mkVec("divu by 0", OP_DIVU, 32'h1234, 32'h0, 64'h0, 64'h0));
        vecs.push_back(mkVec("msub", OP_MSUB, 32'h3, 32'h4, 64'hA, 64'hFFFFFFFF_FFFFFFFE));
        vecs.push_back(mkVec("maddu wrap", OP_MADDU, 32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF, 64'h0));
        vecs.push_back(mkVec("divu", OP_DIVU, 32'd100, 32'd7, 64'h0, 64'h00000002_0000000E));
        vecs.push_back(mkVec("madd neg", OP_MADD, 32'hFFFFFFFD, 32'h4, 64'h5, 64'hFFFFFFFF_FFFFFFF9));
        vecs.push_back(mkVec("div neg divisor", OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h0, 64'h00000001_FFFFFFFD));
        vecs.push_back(mkVec("msubu", OP_MSUBU, 32'h10000, 32'h10000, 64'h2_00000005, 64'h1_00000005));
        for (int i = 0; i < 6; i++) begin
            rv.name = $sformatf("random %0d", i);
            rv.op   = 3'($urandom_range(0, 7));
            rv.a    = $urandom;
            rv.b    = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            rv.hilo = {$urandom, $urandom};
            rv.expResult = refModel(rv.op, rv.a, rv.b, rv.hilo);
            vecs.push_back(rv);
        end

        rst = 1'b1; start = 1'b0; annul = 1'b0;
        op = OP_MULTU; opA = '0; opB = '0; hilo = '0;
        tick();
        tick();
        checkOutput("reset ready", 64'(ready), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset result", result, 64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 0);
        end

        // Annul in the middle of CALC, then relaunch the wrapping signed divide.
        op = OP_MULT; opA = 32'h1234; opB = 32'h5678; hilo = '0;
        start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        tick();
        checkOutput("annul busy", 64'(busy), 64'd0);
        checkOutput("annul ready", 64'(ready), 64'd0);
        annul = 1'b0; start = 1'b0;
        sawReady = 1'b0;
        repeat (40) begin
            tick();
            if (ready) sawReady = 1'b1;
        end
        checkOutput("annul no ready", 64'(sawReady), 64'd0);
        applyStimulus(mkVec("div min by -1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h0,
                            64'h00000000_80000000), 0);

        // Annul held in IDLE blocks the launch.
        annul = 1'b1; start = 1'b1; op = OP_MULTU; opA = 32'h3; opB = 32'h5;
        repeat (3) tick();
        checkOutput("annul idle busy", 64'(busy), 64'd0);
        start = 1'b0; annul = 1'b0;
        tick();

        // Synchronous reset in the middle of CALC.
        start = 1'b1; op = OP_MULTU; opA = 32'hFFFF; opB = 32'hFFFF;
        repeat (6) tick();
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset ready", 64'(ready), 64'd0);
        checkOutput("mid reset result", result, 64'h0);
        rst = 1'b0; start = 1'b0;
        tick();

        // start_i held in DONE: no relaunch and a stable result.
        applyStimulus(mkVec("done hold", OP_MULTU, 32'h10000, 32'h10000, 64'h0, 64'h00000001_00000000), 5);

        cycles = scoreboard.size();
        checkOutput("scoreboard drained", 64'(cycles), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
